// File: rtl/note_player.sv
// Per-voice note controller: latches a note, fetches its phase increment from the
// frequency ROM, gates sine-reader advance requests and counts the note down in beats.
module note_player #(
    parameter int NOTE_W   = 6,
    parameter int DUR_W    = 6,
    parameter int STEP_W   = 20,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                play_enable,
    input  logic [NOTE_W-1:0]   note,
    input  logic [DUR_W-1:0]    duration,
    input  logic                load_new_note,
    input  logic                beat,
    input  logic                generate_next_sample,
    output logic [NOTE_W-1:0]   freq_addr,
    input  logic [STEP_W-1:0]   freq_step,
    output logic [STEP_W-1:0]   step_size,
    output logic                generate_next,
    input  logic [SAMPLE_W-1:0] sine_sample,
    input  logic                sine_ready,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                new_sample_ready,
    output logic                done_with_note,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

    state_t              state_q, state_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [DUR_W-1:0]    remaining_q, remaining_d;
    logic [STEP_W-1:0]   step_size_q, step_size_d;
    logic                done_q, done_d;
    logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;
    logic                nsr_q, nsr_d;

    always_comb begin
        state_d      = state_q;
        note_d       = note_q;
        remaining_d  = remaining_q;
        step_size_d  = step_size_q;
        done_d       = 1'b0;
        sample_out_d = sample_out_q;
        nsr_d        = 1'b0;

        case (state_q)
            IDLE: begin
                step_size_d = '0;
                if (load_new_note) begin
                    note_d      = note;
                    remaining_d = duration;
                    state_d     = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                if (remaining_q == '0) begin
                    // zero-length note finishes immediately and never drives a step
                    done_d      = 1'b1;
                    step_size_d = '0;
                    state_d     = IDLE;
                end else begin
                    step_size_d = (note_q == '0) ? '0 : freq_step;
                    state_d     = PLAY;
                end
            end
            PLAY: begin
                if (beat && play_enable) begin
                    if (remaining_q > DUR_W'(1)) begin
                        remaining_d = remaining_q - DUR_W'(1);
                    end else begin
                        done_d      = 1'b1;
                        step_size_d = '0;
                        state_d     = IDLE;
                        // back-to-back note: accept a load landing on the final beat
                        if (load_new_note) begin
                            note_d      = note;
                            remaining_d = duration;
                            state_d     = FETCH;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (sine_ready) begin
            sample_out_d = (note_q == '0 || state_q == IDLE) ? '0 : sine_sample;
            nsr_d        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            note_q       <= '0;
            remaining_q  <= '0;
            step_size_q  <= '0;
            done_q       <= 1'b0;
            sample_out_q <= '0;
            nsr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            note_q       <= note_d;
            remaining_q  <= remaining_d;
            step_size_q  <= step_size_d;
            done_q       <= done_d;
            sample_out_q <= sample_out_d;
            nsr_q        <= nsr_d;
        end
    end

    assign freq_addr        = note_q;
    assign step_size        = step_size_q;
    assign generate_next    = (state_q == PLAY) && generate_next_sample && play_enable;
    assign sample_out       = sample_out_q;
    assign new_sample_ready = nsr_q;
    assign done_with_note   = done_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: ROM and sine-reader models, a sample scoreboard,
// a table of note vectors and hand-written multi-cycle corner cases.
module tb_note_player;

    localparam int NOTE_W   = 6;
    localparam int DUR_W    = 6;
    localparam int STEP_W   = 20;
    localparam int SAMPLE_W = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                play_enable = 1'b1;
    logic [NOTE_W-1:0]   note = '0;
    logic [DUR_W-1:0]    duration = '0;
    logic                load_new_note = 1'b0;
    logic                beat = 1'b0;
    logic                generate_next_sample = 1'b0;
    logic [NOTE_W-1:0]   freq_addr;
    logic [STEP_W-1:0]   freq_step = '0;
    logic [STEP_W-1:0]   step_size;
    logic                generate_next;
    logic [SAMPLE_W-1:0] sine_sample = '0;
    logic                sine_ready = 1'b0;
    logic [SAMPLE_W-1:0] sample_out;
    logic                new_sample_ready;
    logic                done_with_note;
    logic                busy;

    note_player #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .STEP_W(STEP_W), .SAMPLE_W(SAMPLE_W)) dut (
        .clk(clk), .reset(reset), .play_enable(play_enable), .note(note), .duration(duration),
        .load_new_note(load_new_note), .beat(beat), .generate_next_sample(generate_next_sample),
        .freq_addr(freq_addr), .freq_step(freq_step), .step_size(step_size),
        .generate_next(generate_next), .sine_sample(sine_sample), .sine_ready(sine_ready),
        .sample_out(sample_out), .new_sample_ready(new_sample_ready),
        .done_with_note(done_with_note), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failed    = 0;

    logic [SAMPLE_W-1:0] sb_q[$];
    logic [SAMPLE_W-1:0] exp_sample_val = '0;
    logic                gn_d1 = 1'b0;

    typedef struct {
        logic [NOTE_W-1:0]   note;
        logic [DUR_W-1:0]    dur;
        logic [SAMPLE_W-1:0] sine;
        logic [STEP_W-1:0]   exp_step;
        logic [SAMPLE_W-1:0] exp_sample;
    } vec_t;

    function automatic logic [STEP_W-1:0] rom(input logic [NOTE_W-1:0] a);
        if (a == 6'd49) return 20'h0B1F2;
        return {2'b00, a, 12'h055};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, advance models just after posedge.
    task automatic cyc();
        logic              gn_seen;
        logic [STEP_W-1:0] rom_next;
        logic [SAMPLE_W-1:0] e;
        @(negedge clk);
        gn_seen  = generate_next;
        rom_next = rom(freq_addr);
        if (new_sample_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_sample", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sample_out", sample_out, e);
            end
        end
        @(posedge clk);
        #1;
        load_new_note        = 1'b0;
        beat                 = 1'b0;
        generate_next_sample = 1'b0;
        freq_step            = rom_next;
        sine_ready           = gn_d1;
        if (sine_ready) sb_q.push_back(exp_sample_val);
        gn_d1 = gn_seen;
    endtask

    task automatic load(input logic [NOTE_W-1:0] n, input logic [DUR_W-1:0] d);
        note = n;
        duration = d;
        load_new_note = 1'b1;
    endtask

    // Ten cycles with a sample tick early and a beat on the last cycle.
    task automatic beat_period(input bit tick, input bit exp_gn, input bit last, output bit early_done);
        early_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 1 && tick) begin
                generate_next_sample = 1'b1;
                #1;
                check("generate_next", generate_next, exp_gn);
            end
            if (c == 9) beat = 1'b1;
            cyc();
            if (done_with_note && !(last && c == 9)) early_done = 1'b1;
        end
    endtask

    task automatic run_note(input vec_t v);
        bit early, any_early;
        any_early = 1'b0;
        sine_sample    = v.sine;
        exp_sample_val = v.exp_sample;
        load(v.note, v.dur);
        cyc();
        check("fetch_freq_addr", freq_addr, v.note);
        check("fetch_busy", busy, 1);
        cyc();
        cyc();
        check("play_step_size", step_size, v.exp_step);
        for (int b = 0; b < int'(v.dur); b++) begin
            beat_period(1'b1, 1'b1, b == int'(v.dur) - 1, early);
            if (early) any_early = 1'b1;
        end
        check("no_early_done", any_early, 0);
        check("final_done", done_with_note, 1);
        check("final_step_zero", step_size, 0);
        check("final_busy", busy, 0);
        cyc();
        check("done_one_cycle", done_with_note, 0);
    endtask

    vec_t vecs[4];
    bit   early;
    int   dn;

    initial begin
        vecs[0] = '{note: 6'd49, dur: 6'd3, sine: 16'h7FFF, exp_step: 20'h0B1F2, exp_sample: 16'h7FFF};
        vecs[1] = '{note: 6'd0,  dur: 6'd2, sine: 16'h1234, exp_step: 20'h00000, exp_sample: 16'h0000};
        vecs[2] = '{note: 6'd7,  dur: 6'd1, sine: 16'h8001, exp_step: 20'h07055, exp_sample: 16'h8001};
        vecs[3] = '{note: 6'd63, dur: 6'd2, sine: 16'h0F0F, exp_step: 20'h3F055, exp_sample: 16'h0F0F};

        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_step", step_size, 0);
        check("rst_freq_addr", freq_addr, 0);
        check("rst_done", done_with_note, 0);
        check("rst_nsr", new_sample_ready, 0);
        check("rst_sample", sample_out, 0);

        for (int i = 0; i < 4; i++) run_note(vecs[i]);

        // sine_ready while idle yields a zero sample
        sine_sample = 16'h5555;
        exp_sample_val = 16'h0000;
        gn_d1 = 1'b1;
        cyc();
        cyc();
        cyc();

        // pause mid-note: duration 4, one beat, five paused beats, then three more
        sine_sample = 16'h2222;
        exp_sample_val = 16'h2222;
        load(6'd5, 6'd4);
        cyc(); cyc(); cyc();
        beat_period(1'b1, 1'b1, 1'b0, early);
        check("pause_pre_done", early, 0);
        play_enable = 1'b0;
        dn = 0;
        for (int b = 0; b < 5; b++) begin
            beat_period(1'b1, 1'b0, 1'b0, early);
            if (early) dn++;
        end
        check("pause_no_done", dn, 0);
        check("pause_busy", busy, 1);
        play_enable = 1'b1;
        for (int b = 0; b < 3; b++) begin
            beat_period(1'b1, 1'b1, b == 2, early);
            if (early) dn++;
        end
        check("resume_no_early", dn, 0);
        check("resume_done", done_with_note, 1);
        check("resume_idle", busy, 0);
        cyc();

        // load ignored mid-PLAY, accepted on the final beat
        sine_sample = 16'h0101;
        exp_sample_val = 16'h0101;
        load(6'd10, 6'd2);
        cyc(); cyc(); cyc();
        check("b2b_step_old", step_size, 20'h0A055);
        beat_period(1'b0, 1'b0, 1'b0, early);
        load(6'd30, 6'd5);
        cyc();
        check("midplay_load_ignored_addr", freq_addr, 10);
        check("midplay_load_busy", busy, 1);
        load(6'd20, 6'd1);
        beat = 1'b1;
        cyc();
        check("b2b_done_old", done_with_note, 1);
        check("b2b_fetch_addr", freq_addr, 20);
        check("b2b_busy", busy, 1);
        cyc();
        check("b2b_done_once", done_with_note, 0);
        cyc();
        check("b2b_step_new", step_size, 20'h14055);
        beat = 1'b1;
        cyc();
        check("b2b_done_new", done_with_note, 1);
        check("b2b_idle", busy, 0);
        cyc();

        // zero duration: done three cycles after load, no generate_next
        load(6'd9, 6'd0);
        cyc();
        generate_next_sample = 1'b1;
        #1;
        check("dur0_gn_fetch", generate_next, 0);
        cyc();
        generate_next_sample = 1'b1;
        #1;
        check("dur0_gn_load", generate_next, 0);
        check("dur0_no_done_yet", done_with_note, 0);
        cyc();
        check("dur0_done", done_with_note, 1);
        check("dur0_step", step_size, 0);
        check("dur0_idle", busy, 0);
        cyc();

        // reset in PLAY aborts with no done pulse
        load(6'd12, 6'd3);
        cyc(); cyc(); cyc();
        check("prerst_busy", busy, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_step", step_size, 0);
        check("midrst_addr", freq_addr, 0);
        check("midrst_done", done_with_note, 0);
        check("midrst_sample", sample_out, 0);
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (done_with_note) dn++;
        end
        check("postrst_no_done", dn, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
